// File: rtl/pacman_pkg.sv
// Shared definitions for the Pacman controller: keypad key indices and the
// scanner state encoding, plus a priority helper used on the key snapshot.
package pacman_pkg;

    // Direction keys as row*4+col indices on the 4x4 matrix
    localparam logic [3:0] KEY_UP    = 4'd1;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd9;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } scan_state_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels;
// resets to all ones so idle pulled-up inputs read as inactive.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, snapshots the
// rows once per full scan and debounces the lowest pressed key into clean events.
module keypad_scanner
    import pacman_pkg::*;
#(
    parameter int DWELL_CYCLES   = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

    logic [3:0]    rows_sync;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    cols_q, cols_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   snapshot_q, snapshot_d;
    logic          eval_q, eval_d;

    scan_state_t   state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          dwell_term;
    logic          hit;
    logic [3:0]    cand_now;
    logic          cand_on;
    logic [CW-1:0] cnt_inc;

    sync_2ff #(.W(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (rows),
        .q   (rows_sync)
    );

    assign dwell_term = (dwell_q == DWELL_LAST);

    // Column ring and snapshot; the rows have had the whole dwell to settle
    // through the synchronizer before they are latched at terminal count.
    always_comb begin
        dwell_d    = dwell_q + DW'(1);
        cols_d     = cols_q;
        col_idx_d  = col_idx_q;
        snapshot_d = snapshot_q;
        eval_d     = 1'b0;
        if (eval_q) snapshot_d = '0;
        if (dwell_term) begin
            dwell_d = '0;
            for (int r = 0; r < 4; r++) begin
                snapshot_d[{2'(r), col_idx_q}] = ~rows_sync[r];
            end
            cols_d    = {cols_q[2:0], cols_q[3]};
            col_idx_d = col_idx_q + 2'd1;
            eval_d    = (col_idx_q == 2'd3);
        end
    end

    assign hit      = |snapshot_q;
    assign cand_now = lowest_set(snapshot_q);
    assign cand_on  = snapshot_q[cand_q];
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (eval_q) begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        cand_d = cand_now;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d  = cand_now;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = HELD;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (cand_on) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    // Only the accepted key matters here; others wait for SCAN.
                    if (!cand_on) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            key_down_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = SCAN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!cand_on) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_down_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = SCAN;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q     <= '0;
            cols_q      <= 4'b1110;
            col_idx_q   <= 2'd0;
            snapshot_q  <= '0;
            eval_q      <= 1'b0;
            state_q     <= SCAN;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            cols_q      <= cols_d;
            col_idx_q   <= col_idx_d;
            snapshot_q  <= snapshot_d;
            eval_q      <= eval_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model; expected key
// events are queued as presses are driven and matched against key_valid pulses.
module tb_keypad_scanner;

    localparam logic [3:0] K_R1C2 = 4'd6;
    localparam logic [3:0] K_R2C1 = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  ring[4];

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .DWELL_CYCLES   (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        check("cols_one_low", 32'($countones(~cols)), 32'd1);
        if (key_valid) begin
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("pulse_code", 32'(key_code), 32'(exp_q.pop_front()));
        end
    end

    // Advance to the next scan boundary: first negedge with cols back at 1110.
    task automatic next_scan();
        int n;
        n = 0;
        while (cols !== 4'b0111 && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (cols !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scan_boundary", 32'(cols), 32'(4'b1110));
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) next_scan();
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_down(input string tag, input logic exp);
        check(tag, 32'(key_down), 32'(exp));
    endtask

    initial begin
        ring[0] = 4'b1110;
        ring[1] = 4'b1101;
        ring[2] = 4'b1011;
        ring[3] = 4'b0111;
        pressed = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cols", 32'(cols), 32'(4'b1110));
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check_down("rst_down", 1'b0);

        // 1: free-running column ring, no keys
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            repeat (4) @(negedge clk);
            check("ring_cols", 32'(cols), 32'(ring[i % 4]));
            check("ring_valid", 32'(key_valid), 32'd0);
            check_down("ring_down", 1'b0);
        end

        // 2: single held key, then release
        next_scan();
        pressed[K_R1C2] = 1'b1;
        exp_q.push_back(K_R1C2);
        scans(2);
        settle();
        check_down("t2_early", 1'b0);
        next_scan();
        settle();
        check_down("t2_down", 1'b1);
        check("t2_code", 32'(key_code), 32'(K_R1C2));
        scans(2);
        pressed[K_R1C2] = 1'b0;
        scans(2);
        settle();
        check_down("t2_rel_early", 1'b1);
        next_scan();
        settle();
        check_down("t2_released", 1'b0);
        check("t2_code_kept", 32'(key_code), 32'(K_R1C2));
        check("t2_pending", 32'(exp_q.size()), 32'd0);

        // 3: bounce present/absent, then three clean scans
        next_scan();
        pressed[K_R2C1] = 1'b1;
        next_scan();
        pressed[K_R2C1] = 1'b0;
        next_scan();
        pressed[K_R2C1] = 1'b1;
        exp_q.push_back(K_R2C1);
        scans(2);
        settle();
        check_down("t3_early", 1'b0);
        next_scan();
        settle();
        check_down("t3_down", 1'b1);
        check("t3_code", 32'(key_code), 32'(K_R2C1));
        next_scan();
        pressed[K_R2C1] = 1'b0;
        scans(3);
        settle();
        check_down("t3_released", 1'b0);
        check("t3_pending", 32'(exp_q.size()), 32'd0);

        // 4: two keys, lowest wins; second reported after first releases
        next_scan();
        pressed[5]  = 1'b1;
        pressed[10] = 1'b1;
        exp_q.push_back(4'd5);
        scans(3);
        settle();
        check_down("t4_down5", 1'b1);
        check("t4_code5", 32'(key_code), 32'd5);
        next_scan();
        pressed[5] = 1'b0;
        scans(2);
        settle();
        check_down("t4_still_down", 1'b1);
        next_scan();
        settle();
        check_down("t4_released5", 1'b0);
        check("t4_code_kept5", 32'(key_code), 32'd5);
        exp_q.push_back(4'd10);
        scans(2);
        settle();
        check_down("t4_early10", 1'b0);
        next_scan();
        settle();
        check_down("t4_down10", 1'b1);
        check("t4_code10", 32'(key_code), 32'd10);
        next_scan();
        pressed[10] = 1'b0;
        scans(3);
        settle();
        check_down("t4_released10", 1'b0);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // 5: held key drops out for one scan only
        next_scan();
        pressed[0] = 1'b1;
        exp_q.push_back(4'd0);
        scans(3);
        settle();
        check_down("t5_down", 1'b1);
        check("t5_code", 32'(key_code), 32'd0);
        next_scan();
        pressed[0] = 1'b0;
        next_scan();
        pressed[0] = 1'b1;
        settle();
        check_down("t5_glitch", 1'b1);
        scans(3);
        settle();
        check_down("t5_held", 1'b1);
        next_scan();
        pressed[0] = 1'b0;
        scans(3);
        settle();
        check_down("t5_released", 1'b0);
        check("t5_pending", 32'(exp_q.size()), 32'd0);

        // 6a: reset while confirming
        next_scan();
        pressed[K_R1C2] = 1'b1;
        next_scan();
        settle();
        check_down("t6_confirming", 1'b0);
        rst = 1'b1;
        #1;
        check("t6a_cols", 32'(cols), 32'(4'b1110));
        check("t6a_valid", 32'(key_valid), 32'd0);
        check_down("t6a_down", 1'b0);
        check("t6a_code", 32'(key_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(K_R1C2);
        scans(2);
        settle();
        check_down("t6a_early", 1'b0);
        next_scan();
        settle();
        check_down("t6a_reconfirm", 1'b1);
        check("t6a_code6", 32'(key_code), 32'(K_R1C2));

        // 6b: reset while held, key kept pressed through it
        next_scan();
        rst = 1'b1;
        #1;
        check("t6b_cols", 32'(cols), 32'(4'b1110));
        check("t6b_valid", 32'(key_valid), 32'd0);
        check_down("t6b_down", 1'b0);
        check("t6b_code", 32'(key_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(K_R1C2);
        scans(2);
        settle();
        check_down("t6b_early", 1'b0);
        next_scan();
        settle();
        check_down("t6b_reconfirm", 1'b1);
        check("t6b_code6", 32'(key_code), 32'(K_R1C2));
        next_scan();
        pressed[K_R1C2] = 1'b0;
        scans(3);
        settle();
        check_down("t6b_released", 1'b0);
        check("t6_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
